// File: rtl/ctl_round_pkg.sv
// ctl_round_pkg -- shared definitions for the duck-hunt round controller.
//   state_t      : round FSM state, also exported on the debug 'state' port
//   bcd_digit_t  : one packed BCD digit
//   bin_to_bcd2  : constant helper turning a small integer into two BCD digits
package ctl_round_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    FLYING    = 3'd2,
    WAVE_END  = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic [7:0] bin_to_bcd2(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// bcd_counter -- combinational saturating BCD adder for small increments.
//   i_val : packed BCD value, DIGITS digits
//   i_inc : amount to add (0..4)
//   o_sum : i_val + i_inc in BCD, clamped at all nines
module bcd_counter
  import ctl_round_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] i_val,
  input  logic [2:0]          i_inc,
  output logic [4*DIGITS-1:0] o_sum
);

  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  // Single BCD +1 with ripple carry; all nines is a fixed point.
  function automatic logic [4*DIGITS-1:0] inc_one(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                carry;
    bcd_digit_t          d;
    r     = v;
    carry = (v != ALL_NINES);
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          d = 4'd0;
        end else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end
      r[4*k +: 4] = d;
    end
    return r;
  endfunction

  // At most four ducks can score in one cycle, so the increment is unrolled.
  always_comb begin
    logic [4*DIGITS-1:0] acc;
    acc = i_val;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(i_inc)) acc = inc_one(acc);
    end
    o_sum = acc;
  end

endmodule

// File: rtl/ctl_round.sv
// ctl_round -- round/wave controller for a light-gun duck game.
//   clk, rst (async, active-low)
//   new_frame    : frame tick, paces the pause between waves
//   start        : level, begins a round from IDLE or GAME_OVER
//   shot_fired   : trigger pulse; hit[] is qualified by it
//   hit, duck_escaped : per-duck pulses
//   duck_launch  : per-duck pulse at wave start
//   duck_flee    : live ducks once the gun is empty
//   score_bcd, ammo_bcd, wave_bcd, game_over, state : registered status
module ctl_round
  import ctl_round_pkg::*;
#(
  parameter int N_DUCKS         = 2,
  parameter int AMMO_PER_WAVE   = 3,
  parameter int WAVES_PER_ROUND = 10,
  parameter int MISS_LIMIT      = 5,
  parameter int PAUSE_FRAMES    = 60,
  parameter int SCORE_DIGITS    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      new_frame,
  input  logic                      start,
  input  logic                      shot_fired,
  input  logic [N_DUCKS-1:0]        hit,
  input  logic [N_DUCKS-1:0]        duck_escaped,
  output logic [N_DUCKS-1:0]        duck_launch,
  output logic [N_DUCKS-1:0]        duck_flee,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [3:0]                ammo_bcd,
  output logic [7:0]                wave_bcd,
  output logic                      game_over,
  output logic [2:0]                state
);

  localparam logic [N_DUCKS-1:0] ALL_DUCKS  = '1;
  localparam logic [7:0]         LAST_WAVE  = bin_to_bcd2(WAVES_PER_ROUND);
  localparam logic [3:0]         AMMO_INIT  = 4'(AMMO_PER_WAVE);
  localparam logic [7:0]         MISS_MAX   = 8'(MISS_LIMIT);
  localparam int                 PAUSE_W    = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_FRAMES - 1);

  state_t                    r_state;
  logic [N_DUCKS-1:0]        r_alive;
  logic [N_DUCKS-1:0]        r_launch;
  logic [N_DUCKS-1:0]        r_flee;
  logic [4*SCORE_DIGITS-1:0] r_score;
  logic [3:0]                r_ammo;
  logic [7:0]                r_wave;
  logic [7:0]                r_misses;
  logic [PAUSE_W-1:0]        r_pause;
  logic                      r_game_over;

  logic                      w_shot_ok;
  logic [N_DUCKS-1:0]        w_hit_q;
  logic [N_DUCKS-1:0]        w_esc_q;
  logic [N_DUCKS-1:0]        w_alive_nx;
  logic [3:0]                w_ammo_nx;
  logic [2:0]                w_hit_cnt;
  logic [2:0]                w_esc_cnt;
  logic [7:0]                w_miss_sum;
  logic [7:0]                w_miss_nx;
  logic [4*SCORE_DIGITS-1:0] w_score_nx;
  logic [7:0]                w_wave_nx;

  function automatic logic [2:0] popcnt(input logic [N_DUCKS-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int k = 0; k < N_DUCKS; k++) c = c + {2'b00, v[k]};
    return c;
  endfunction

  // A hit only counts on a live duck with a shot that actually left the gun;
  // a hit on the same duck masks its escape so no miss is charged.
  assign w_shot_ok  = shot_fired && (r_ammo != 4'd0);
  assign w_hit_q    = hit & r_alive & {N_DUCKS{w_shot_ok}};
  assign w_esc_q    = duck_escaped & r_alive & ~w_hit_q;
  assign w_alive_nx = r_alive & ~(w_hit_q | w_esc_q);
  assign w_ammo_nx  = w_shot_ok ? (r_ammo - 4'd1) : r_ammo;
  assign w_hit_cnt  = popcnt(w_hit_q);
  assign w_esc_cnt  = popcnt(w_esc_q);
  assign w_miss_sum = r_misses + {5'b0, w_esc_cnt};
  assign w_miss_nx  = (w_miss_sum >= MISS_MAX) ? MISS_MAX : w_miss_sum;

  bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score_inc (
    .i_val (r_score),
    .i_inc (w_hit_cnt),
    .o_sum (w_score_nx)
  );

  bcd_counter #(.DIGITS(2)) u_wave_inc (
    .i_val (r_wave),
    .i_inc (3'd1),
    .o_sum (w_wave_nx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_alive     <= '0;
      r_launch    <= '0;
      r_flee      <= '0;
      r_score     <= '0;
      r_ammo      <= '0;
      r_wave      <= '0;
      r_misses    <= '0;
      r_pause     <= '0;
      r_game_over <= 1'b0;
    end else begin
      r_launch <= '0;
      case (r_state)
        IDLE, GAME_OVER: begin
          if (start) begin
            r_state     <= LAUNCH;
            r_score     <= '0;
            r_misses    <= '0;
            r_wave      <= 8'h01;
            r_launch    <= ALL_DUCKS;
            r_alive     <= ALL_DUCKS;
            r_ammo      <= AMMO_INIT;
            r_game_over <= 1'b0;
          end
        end
        LAUNCH: r_state <= FLYING;
        FLYING: begin
          r_alive  <= w_alive_nx;
          r_ammo   <= w_ammo_nx;
          r_score  <= w_score_nx;
          r_misses <= w_miss_nx;
          if (w_alive_nx == '0) begin
            r_state <= WAVE_END;
            r_flee  <= '0;
          end else begin
            // flee mirrors the post-update alive mask once the gun is empty
            r_flee <= (w_ammo_nx == 4'd0) ? w_alive_nx : '0;
          end
        end
        WAVE_END: begin
          if (new_frame) begin
            if (r_pause == PAUSE_LAST) begin
              r_pause <= '0;
              if (r_wave == LAST_WAVE || r_misses >= MISS_MAX) begin
                r_state     <= GAME_OVER;
                r_game_over <= 1'b1;
              end else begin
                r_state  <= LAUNCH;
                r_wave   <= w_wave_nx;
                r_launch <= ALL_DUCKS;
                r_alive  <= ALL_DUCKS;
                r_ammo   <= AMMO_INIT;
              end
            end else begin
              r_pause <= r_pause + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign state       = r_state;
  assign duck_launch = r_launch;
  assign duck_flee   = r_flee;
  assign score_bcd   = r_score;
  assign ammo_bcd    = r_ammo;
  assign wave_bcd    = r_wave;
  assign game_over   = r_game_over;

endmodule

// File: tb/tb_ctl_round.sv
// tb_ctl_round -- self-checking bench for ctl_round: directed round scenarios
// plus randomized play, every cycle compared against an integer game model.
`timescale 1ns/1ps
module tb_ctl_round;
  import ctl_round_pkg::*;

  localparam int N_DUCKS         = 2;
  localparam int AMMO_PER_WAVE   = 3;
  localparam int WAVES_PER_ROUND = 60;
  localparam int MISS_LIMIT      = 5;
  localparam int PAUSE_FRAMES    = 60;
  localparam int SCORE_DIGITS    = 2;
  localparam int SCORE_MAX       = 10 ** SCORE_DIGITS - 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      new_frame;
  logic                      start;
  logic                      shot_fired;
  logic [N_DUCKS-1:0]        hit;
  logic [N_DUCKS-1:0]        duck_escaped;
  logic [N_DUCKS-1:0]        duck_launch;
  logic [N_DUCKS-1:0]        duck_flee;
  logic [4*SCORE_DIGITS-1:0] score_bcd;
  logic [3:0]                ammo_bcd;
  logic [7:0]                wave_bcd;
  logic                      game_over;
  logic [2:0]                state;

  ctl_round #(
    .N_DUCKS(N_DUCKS), .AMMO_PER_WAVE(AMMO_PER_WAVE), .WAVES_PER_ROUND(WAVES_PER_ROUND),
    .MISS_LIMIT(MISS_LIMIT), .PAUSE_FRAMES(PAUSE_FRAMES), .SCORE_DIGITS(SCORE_DIGITS)
  ) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .start(start), .shot_fired(shot_fired),
    .hit(hit), .duck_escaped(duck_escaped), .duck_launch(duck_launch), .duck_flee(duck_flee),
    .score_bcd(score_bcd), .ammo_bcd(ammo_bcd), .wave_bcd(wave_bcd), .game_over(game_over),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // game model: plain integers, one duck at a time
  state_t             m_state;
  int                 m_score, m_ammo, m_wave, m_miss, m_pause;
  logic [N_DUCKS-1:0] m_alive, m_launch;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state = IDLE; m_score = 0; m_ammo = 0; m_wave = 0; m_miss = 0; m_pause = 0;
    m_alive = '0; m_launch = '0;
  endtask

  task automatic model_launch();
    m_state  = LAUNCH;
    m_alive  = '1;
    m_ammo   = AMMO_PER_WAVE;
    m_launch = '1;
  endtask

  task automatic model_step();
    bit shot_ok;
    m_launch = '0;
    case (m_state)
      IDLE, GAME_OVER: if (start) begin
        m_score = 0; m_miss = 0; m_wave = 1;
        model_launch();
      end
      LAUNCH: m_state = FLYING;
      FLYING: begin
        shot_ok = shot_fired && (m_ammo > 0);
        for (int i = 0; i < N_DUCKS; i++) begin
          if (m_alive[i]) begin
            if (shot_ok && hit[i]) begin
              m_alive[i] = 1'b0;
              if (m_score < SCORE_MAX) m_score++;
            end else if (duck_escaped[i]) begin
              m_alive[i] = 1'b0;
              if (m_miss < MISS_LIMIT) m_miss++;
            end
          end
        end
        if (shot_ok) m_ammo--;
        if (m_alive == '0) m_state = WAVE_END;
      end
      WAVE_END: if (new_frame) begin
        m_pause++;
        if (m_pause == PAUSE_FRAMES) begin
          m_pause = 0;
          if (m_wave == WAVES_PER_ROUND || m_miss >= MISS_LIMIT) m_state = GAME_OVER;
          else begin
            m_wave++;
            model_launch();
          end
        end
      end
      default: m_state = IDLE;
    endcase
  endtask

  task automatic check_all();
    logic [N_DUCKS-1:0] exp_flee;
    exp_flee = (m_state == FLYING && m_ammo == 0) ? m_alive : '0;
    chk("state",     32'(state),       32'(m_state));
    chk("score",     32'(score_bcd),   to_bcd(m_score));
    chk("ammo",      32'(ammo_bcd),    to_bcd(m_ammo));
    chk("wave",      32'(wave_bcd),    to_bcd(m_wave));
    chk("game_over", 32'(game_over),   32'(m_state == GAME_OVER));
    chk("launch",    32'(duck_launch), 32'(m_launch));
    chk("flee",      32'(duck_flee),   32'(exp_flee));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic tick(input logic st, input logic nf, input logic sh,
                      input logic [N_DUCKS-1:0] h, input logic [N_DUCKS-1:0] e);
    start = st; new_frame = nf; shot_fired = sh; hit = h; duck_escaped = e;
    cycle();
  endtask

  // random frame ticks and stray gun/duck pulses, never start
  task automatic noise_tick();
    start        = 1'b0;
    new_frame    = 1'($urandom % 2);
    shot_fired   = 1'($urandom % 2);
    hit          = N_DUCKS'($urandom);
    duck_escaped = N_DUCKS'($urandom);
    cycle();
  endtask

  task automatic wait_state(input state_t tgt);
    int n;
    n = 0;
    while (state !== 3'(tgt) && n < 1000) begin
      noise_tick();
      n++;
    end
    chk("wait_state", 32'(state), 32'(tgt));
  endtask

  task automatic do_reset();
    start = 1'b0; new_frame = 1'b0; shot_fired = 1'b0; hit = '0; duck_escaped = '0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; new_frame = 1'b0; shot_fired = 1'b0; hit = '0; duck_escaped = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b1;

    // round 1: double hits every wave to drive the score into saturation
    tick(1, 0, 0, 2'b00, 2'b00);
    chk("start_state", 32'(state), 32'(LAUNCH));
    chk("start_launch", 32'(duck_launch), 32'h3);
    chk("start_ammo", 32'(ammo_bcd), 32'h3);
    chk("start_wave", 32'(wave_bcd), 32'h01);
    tick(0, 0, 0, 2'b00, 2'b00);
    chk("launch_1cyc", 32'(duck_launch), 32'h0);
    for (int w = 1; w <= 49; w++) begin
      tick(0, 0, 1, 2'b11, 2'b00);
      wait_state(LAUNCH);
      tick(0, 0, 0, 2'b00, 2'b00);
    end
    chk("score_98", 32'(score_bcd), 32'h98);
    tick(0, 0, 1, 2'b11, 2'b00);
    chk("sat_double", 32'(score_bcd), 32'h99);
    wait_state(LAUNCH);
    tick(0, 0, 0, 2'b00, 2'b00);
    tick(0, 0, 1, 2'b01, 2'b00);
    chk("sat_single", 32'(score_bcd), 32'h99);
    chk("pre_rst_flying", 32'(state), 32'(FLYING));

    // reset mid-wave abandons it; nothing launches until start
    do_reset();
    chk("rst_mid_score", 32'(score_bcd), 32'h0);
    for (int k = 0; k < 8; k++) noise_tick();
    chk("rst_no_launch", 32'(duck_launch), 32'h0);
    chk("rst_wait_idle", 32'(state), 32'(IDLE));

    // round 2: scoring, empty gun, simultaneous hit/escape, miss limit
    tick(1, 0, 0, 2'b00, 2'b00);
    tick(0, 0, 0, 2'b00, 2'b00);
    tick(0, 0, 1, 2'b01, 2'b00);
    tick(0, 0, 1, 2'b10, 2'b00);
    chk("two_hit_score", 32'(score_bcd), 32'h02);
    chk("two_hit_ammo", 32'(ammo_bcd), 32'h1);
    chk("two_hit_state", 32'(state), 32'(WAVE_END));
    wait_state(LAUNCH);
    chk("wave2", 32'(wave_bcd), 32'h02);
    tick(0, 0, 0, 2'b00, 2'b00);
    repeat (3) tick(0, 0, 1, 2'b00, 2'b00);
    chk("empty_ammo", 32'(ammo_bcd), 32'h0);
    chk("empty_flee", 32'(duck_flee), 32'h3);
    tick(0, 0, 0, 2'b00, 2'b11);
    chk("escape_state", 32'(state), 32'(WAVE_END));
    wait_state(LAUNCH);
    tick(0, 0, 0, 2'b00, 2'b00);
    tick(0, 0, 1, 2'b01, 2'b01);
    chk("hit_esc_score", 32'(score_bcd), 32'h03);
    tick(0, 0, 1, 2'b00, 2'b00);
    tick(0, 0, 1, 2'b00, 2'b00);
    chk("flee_one", 32'(duck_flee), 32'h2);
    tick(0, 0, 1, 2'b10, 2'b00);
    chk("dry_shot_score", 32'(score_bcd), 32'h03);
    chk("dry_shot_ammo", 32'(ammo_bcd), 32'h0);
    chk("dry_shot_state", 32'(state), 32'(FLYING));
    tick(0, 0, 0, 2'b00, 2'b10);
    wait_state(LAUNCH);
    tick(0, 0, 0, 2'b00, 2'b00);
    tick(0, 0, 0, 2'b00, 2'b11);
    wait_state(GAME_OVER);
    chk("miss_game_over", 32'(game_over), 32'h1);
    for (int k = 0; k < 6; k++) noise_tick();
    chk("over_holds", 32'(state), 32'(GAME_OVER));
    tick(1, 0, 0, 2'b00, 2'b00);
    chk("restart_score", 32'(score_bcd), 32'h0);
    chk("restart_over", 32'(game_over), 32'h0);
    chk("restart_state", 32'(state), 32'(LAUNCH));

    // randomized play
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      start        = (($urandom % 16) == 0);
      new_frame    = 1'($urandom % 2);
      shot_fired   = (($urandom % 3) == 0);
      hit          = N_DUCKS'($urandom);
      duck_escaped = (($urandom % 4) == 0) ? N_DUCKS'($urandom) : '0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctl_round.md
CTL_ROUND -- requirements
Module: ctl_round

Interface
REQ-001 The block SHALL take parameter N_DUCKS, default 2, giving the number of simultaneous duck channels (legal range 1..4).
REQ-002 The block SHALL take parameter AMMO_PER_WAVE, default 3, giving the shots per wave (legal range 1..9).
REQ-003 The block SHALL take parameter WAVES_PER_ROUND, default 10, giving the waves before the round ends (legal range 1..99).
REQ-004 The block SHALL take parameter MISS_LIMIT, default 5, giving the escaped ducks that end the game early.
REQ-005 The block SHALL take parameter PAUSE_FRAMES, default 60, giving the frames idled in WAVE_END before the next launch.
REQ-006 The block SHALL take parameter SCORE_DIGITS, default 2, giving the BCD score digits (legal range 1..4).
REQ-007 Port clk, input, 1 bit: the single clock for all logic.
REQ-008 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port new_frame, input, 1 bit: one-cycle pulse per video frame.
REQ-010 Port start, input, 1 bit: level; starts a round when in IDLE or GAME_OVER.
REQ-011 Port shot_fired, input, 1 bit: one-cycle pulse per trigger pull.
REQ-012 Port hit, input, N_DUCKS bits: per-duck one-cycle pulse, valid only when coincident with shot_fired.
REQ-013 Port duck_escaped, input, N_DUCKS bits: per-duck one-cycle pulse when the duck leaves the screen.
REQ-014 Port duck_launch, output, N_DUCKS bits: one-cycle pulse per duck at wave start.
REQ-015 Port duck_flee, output, N_DUCKS bits: level; tells a live duck to fly off.
REQ-016 Port score_bcd, output, 4*SCORE_DIGITS bits: packed BCD score.
REQ-017 Port ammo_bcd, output, 4 bits: remaining shots in BCD.
REQ-018 Port wave_bcd, output, 8 bits: current wave, 2 BCD digits.
REQ-019 Port game_over, output, 1 bit: level, high in GAME_OVER.
REQ-020 Port state, output, 3 bits: current FSM state, for debug LEDs.

Function
REQ-021 The FSM SHALL have states IDLE, LAUNCH, FLYING, WAVE_END and GAME_OVER, held in a registered state with all outputs registered.
- IDLE to LAUNCH on start=1: clear score, clear misses, set wave=1.
- LAUNCH lasts exactly one cycle: pulse duck_launch all-ones, set alive mask all-ones, set ammo=AMMO_PER_WAVE, then go to FLYING.
- FLYING to WAVE_END when the alive mask becomes zero.
- WAVE_END counts PAUSE_FRAMES new_frame pulses; then go to GAME_OVER if wave==WAVES_PER_ROUND or misses>=MISS_LIMIT, otherwise wave+1 and go to LAUNCH.
- GAME_OVER to LAUNCH on start=1, with the same clears as from IDLE.
REQ-022 In FLYING, a shot_fired with ammo>0 SHALL decrement ammo by 1 in the following cycle; a shot with ammo==0 is ignored.
REQ-023 In FLYING, when shot_fired is high, ammo>0, hit[i]=1 and alive[i]=1, the block SHALL clear alive[i] and add 1 to the score in BCD, with one increment per set bit.
- A multi-duck hit in one cycle adds popcount of the qualifying bits.
- The score saturates at all nines.
REQ-024 hit bits without a coincident valid shot, or on dead ducks, SHALL be ignored.
REQ-025 duck_escaped[i] with alive[i]=1 SHALL clear alive[i] and increment misses, saturating at MISS_LIMIT; escapes of dead ducks are ignored.
REQ-026 When hit[i] and duck_escaped[i] coincide on a live duck, the hit SHALL take priority and no miss is counted.
REQ-027 duck_flee SHALL equal the alive mask whenever ammo==0 in FLYING, and zero otherwise.
REQ-028 A shot, a hit and an escape on different ducks in the same cycle SHALL all be applied.
REQ-029 Latency from input to output SHALL be 1 cycle (state, score and ammo registered).
REQ-030 Inputs outside FLYING SHALL be ignored, except start.

Reset
REQ-031 When rst=0, asynchronously, the block SHALL reset to:
- state=IDLE
- score_bcd=0, ammo_bcd=0, wave_bcd=0
- duck_launch=0, duck_flee=0, game_over=0
- alive=0, misses=0, pause counter=0
REQ-032 Reset asserted mid-wave SHALL abandon the wave with no launch pulse on release; the block waits for start.

Structure
REQ-033 The state enum and the BCD digit type SHALL live in the shared DH package.
REQ-034 The BCD saturating incrementer SHALL be a sub-module, bcd_counter, parametrised by digit count; it is reused for score and wave.

Verification
REQ-035 Start in IDLE -> next cycle LAUNCH, duck_launch=2'b11 for 1 cycle, ammo_bcd=3, wave_bcd=8'h01.
REQ-036 shot+hit=2'b01, then shot+hit=2'b10 -> score_bcd=8'h02, ammo_bcd=1, WAVE_END; after 60 frames wave_bcd=8'h02.
REQ-037 Three shots with no hits -> ammo_bcd=0, duck_flee=2'b11; duck_escaped=2'b11 -> misses=2, WAVE_END.
REQ-038 Score preloaded at 8'h99, then a hit -> score stays 8'h99; a double hit from 8'h98 -> 8'h99 (saturated).
REQ-039 Same-cycle hit[0] and duck_escaped[0] -> score +1, misses unchanged; a fourth shot at ammo 0 -> no change.
REQ-040 rst=0 during FLYING -> all outputs zero, IDLE; MISS_LIMIT reached -> game_over=1 after the pause; start -> score cleared.
